// File: rtl/operand_pkg.sv
// Shared types and sizes for the register-read operand stage.
// Optional write-before-read bypass is enabled with `OPERAND_STAGE_BYPASS_EN.
package operand_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;

    typedef struct packed {
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b_reg;
        logic [XLEN-1:0] op_imm;
        logic            alu_src;
    } operand_bundle_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;
endpackage

// File: rtl/regfile_2r1w.sv
// 32x64 register file: two combinational reads, one synchronous write, x0 hardwired to 0.
// `OPERAND_STAGE_BYPASS_EN forwards a same-cycle write to the read ports.
module regfile_2r1w
    import operand_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    output logic [XLEN-1:0]       rs1_data_o,
    output logic [XLEN-1:0]       rs2_data_o,
    input  logic                  wb_en_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [XLEN-1:0]       wb_data_i
);
    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wb_en_i && wb_addr_i != '0) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    always_comb begin
        rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
        rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
`ifdef OPERAND_STAGE_BYPASS_EN
        if (wb_en_i && rs1_addr_i != '0 && wb_addr_i == rs1_addr_i) rs1_data_o = wb_data_i;
        if (wb_en_i && rs2_addr_i != '0 && wb_addr_i == rs2_addr_i) rs2_data_o = wb_data_i;
`endif
    end
endmodule

// File: rtl/operand_stage.sv
// Register-read stage: snapshots rs1/rs2/imm/alu_src into a 2-entry skid buffer.
// Bypass of same-cycle write-back is selected by `OPERAND_STAGE_BYPASS_EN (in regfile_2r1w).
module operand_stage
    import operand_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       imm,
    input  logic                  alu_src_in,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       op_a,
    output logic [XLEN-1:0]       op_b_reg,
    output logic [XLEN-1:0]       op_imm,
    output logic                  alu_src
);
    buf_state_e      state_q;
    operand_bundle_t head_q, skid_q, new_b;
    logic            out_valid_q, in_ready_q;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            accept, pop;

    regfile_2r1w u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1_addr_i(rs1_addr),
        .rs2_addr_i(rs2_addr),
        .rs1_data_o(rs1_data),
        .rs2_data_o(rs2_data),
        .wb_en_i   (wb_en),
        .wb_addr_i (wb_addr),
        .wb_data_i (wb_data)
    );

    assign new_b  = '{op_a: rs1_data, op_b_reg: rs2_data, op_imm: imm, alu_src: alu_src_in};
    assign accept = in_valid && in_ready_q;
    assign pop    = out_valid_q && out_ready;

    // in_ready is a registered function of occupancy, so it never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BUF_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state_q     <= BUF_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        head_q      <= new_b;
                        state_q     <= BUF_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    case ({accept, pop})
                        2'b10: begin
                            skid_q     <= new_b;
                            state_q    <= BUF_TWO;
                            in_ready_q <= 1'b0;
                        end
                        2'b01: begin
                            state_q     <= BUF_EMPTY;
                            out_valid_q <= 1'b0;
                        end
                        2'b11:   head_q <= new_b;
                        default: ;
                    endcase
                end
                BUF_TWO: begin
                    if (pop) begin
                        head_q     <= skid_q;
                        state_q    <= BUF_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= BUF_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign op_a      = head_q.op_a;
    assign op_b_reg  = head_q.op_b_reg;
    assign op_imm    = head_q.op_imm;
    assign alu_src   = head_q.alu_src;
endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios plus randomized traffic
// against a queue/array reference model.
module tb_operand_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] imm;
    logic        alu_src_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [63:0] op_a, op_b_reg, op_imm;
    logic        alu_src;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] i;
        logic        s;
    } mb_t;

    mb_t         q[$];
    logic [63:0] mregs [32];

    operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .imm(imm), .alu_src_in(alu_src_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b_reg(op_b_reg), .op_imm(op_imm), .alu_src(alu_src)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
`ifdef OPERAND_STAGE_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return mregs[a];
    endfunction

    // Advance the reference model by one cycle using the current inputs, then move to the next negedge.
    task automatic tick();
        mb_t nb;
        bit  rdy, vld;
        nb.a = mread(rs1_addr);
        nb.b = mread(rs2_addr);
        nb.i = imm;
        nb.s = alu_src_in;
        rdy = (q.size() < 2);
        vld = (q.size() > 0);
        if (flush) q.delete();
        else begin
            if (vld && out_ready) void'(q.pop_front());
            if (in_valid && rdy) q.push_back(nb);
        end
        if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; rs1_addr = 0; rs2_addr = 0; imm = 0; alu_src_in = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 0;
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        q.delete();
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
        checks++; if ({op_a, op_b_reg, op_imm, alu_src} !== '0) begin errors++;
            $display("FAIL reset_outputs got %0h %0h %0h %0h exp 0", op_a, op_b_reg, op_imm, alu_src); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        wr(5'd5, 64'd20);
        wr(5'd6, 64'd40);
        in_valid = 1; rs1_addr = 5; rs2_addr = 6; imm = 64'd40; alu_src_in = 1; out_ready = 0;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0h exp 1", out_valid); end
        checks++; if (op_a !== 64'd20) begin errors++; $display("FAIL basic_op_a got %0d exp 20", op_a); end
        checks++; if (op_b_reg !== 64'd40) begin errors++; $display("FAIL basic_op_b got %0d exp 40", op_b_reg); end
        checks++; if (op_imm !== 64'd40) begin errors++; $display("FAIL basic_imm got %0d exp 40", op_imm); end
        checks++; if (alu_src !== 1'b1) begin errors++; $display("FAIL basic_alu_src got %0h exp 1", alu_src); end
        drain();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %0h exp 0", out_valid); end
    endtask

    task automatic test_x0();
        wr(5'd0, 64'd99);
        in_valid = 1; rs1_addr = 0; rs2_addr = 5; imm = 64'd1; alu_src_in = 0;
        tick();
        in_valid = 0;
        checks++; if (op_a !== 64'd0) begin errors++; $display("FAIL x0_read got %0d exp 0", op_a); end
        checks++; if (op_b_reg !== 64'd20) begin errors++; $display("FAIL x0_rs2 got %0d exp 20", op_b_reg); end
        drain();
    endtask

    task automatic test_bypass();
        logic [63:0] exp;
`ifdef OPERAND_STAGE_BYPASS_EN
        exp = 64'd123;
`else
        exp = 64'd5;
`endif
        wr(5'd7, 64'd5);
        wb_en = 1; wb_addr = 7; wb_data = 64'd123;
        in_valid = 1; rs1_addr = 7; rs2_addr = 0; imm = 64'd3; alu_src_in = 1;
        tick();
        in_valid = 0; wb_en = 0;
        checks++; if (op_a !== exp) begin errors++; $display("FAIL bypass_op_a got %0d exp %0d", op_a, exp); end
        drain();
        in_valid = 1; rs1_addr = 7;
        tick();
        in_valid = 0;
        checks++; if (op_a !== 64'd123) begin errors++; $display("FAIL after_write_op_a got %0d exp 123", op_a); end
        drain();
    endtask

    task automatic test_stall();
        logic [63:0] imms [3];
        logic [63:0] got[$];
        int  sent = 0;
        bit  acc;
        imms[0] = 64'hA; imms[1] = 64'hB; imms[2] = 64'hC;
        out_ready = 0; rs1_addr = 5; rs2_addr = 6; alu_src_in = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; imm = imms[sent];
            acc = (q.size() < 2);
            tick();
            if (acc) sent++;
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0h exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || op_imm !== 64'hA) begin errors++;
            $display("FAIL stall_head got v=%0h imm=%0h exp v=1 imm=a", out_valid, op_imm); end
        out_ready = 1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) got.push_back(op_imm);
            if (sent < 3) begin in_valid = 1; imm = imms[sent]; end
            else in_valid = 0;
            acc = in_valid && (q.size() < 2);
            tick();
            if (acc) sent++;
        end
        in_valid = 0; out_ready = 0;
        checks++; if (got.size() != 3) begin errors++; $display("FAIL stall_count got %0d exp 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] !== imms[i]) begin errors++;
                $display("FAIL stall_order[%0d] got %0h exp %0h", i, got[i], imms[i]); end
        end
    endtask

    task automatic test_flush();
        out_ready = 0; rs1_addr = 5; rs2_addr = 6; alu_src_in = 1;
        in_valid = 1; imm = 64'h11; tick();
        imm = 64'h22; tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full got %0h exp 0", in_ready); end
        imm = 64'hDD; flush = 1; tick();
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0h exp 1", in_ready); end
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++;
                $display("FAIL flush_dropped got v=%0h imm=%0h exp v=0", out_valid, op_imm); end
        end
        out_ready = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            rs1_addr   = 5'($urandom_range(0, 7));
            rs2_addr   = 5'($urandom_range(0, 7));
            imm        = {$urandom, $urandom};
            alu_src_in = 1'($urandom);
            wb_en      = 1'($urandom);
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = {$urandom, $urandom};
            flush      = ($urandom_range(0, 15) == 0);
            checks++; if (in_ready !== (q.size() < 2)) begin errors++;
                $display("FAIL rnd_in_ready cyc %0d got %0h exp %0h", c, in_ready, q.size() < 2); end
            checks++; if (out_valid !== (q.size() > 0)) begin errors++;
                $display("FAIL rnd_out_valid cyc %0d got %0h exp %0h", c, out_valid, q.size() > 0); end
            if (q.size() > 0) begin
                checks++;
                if (op_a !== q[0].a || op_b_reg !== q[0].b || op_imm !== q[0].i || alu_src !== q[0].s) begin
                    errors++;
                    $display("FAIL rnd_head cyc %0d got %0h %0h %0h %0h exp %0h %0h %0h %0h", c,
                             op_a, op_b_reg, op_imm, alu_src, q[0].a, q[0].b, q[0].i, q[0].s);
                end
            end
            tick();
        end
        in_valid = 0; wb_en = 0; flush = 0;
        drain();
    endtask

    task automatic test_async_reset();
        wr(5'd5, 64'd77);
        out_ready = 0; rs1_addr = 5; rs2_addr = 5; alu_src_in = 1;
        in_valid = 1; imm = 64'h55; tick();
        imm = 64'h66; tick();
        in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0h exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %0h exp 1", in_ready); end
        checks++; if ({op_a, op_b_reg, op_imm, alu_src} !== '0) begin errors++;
            $display("FAIL arst_outputs got %0h %0h %0h %0h exp 0", op_a, op_b_reg, op_imm, alu_src); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1; imm = 64'h9; tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || op_a !== 64'd0 || op_b_reg !== 64'd0) begin errors++;
            $display("FAIL arst_x5 got v=%0h a=%0h b=%0h exp v=1 a=0 b=0", out_valid, op_a, op_b_reg); end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x0();
        test_bypass();
        test_stall();
        test_flush();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
